// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider (div_ctrl / div_step).
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_STEPS  = DIV_DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        BY_ZERO,
        ON,
        END
    } div_state_t;

    // HI/LO write-path packing: remainder lands in HI, quotient in LO.
    function automatic logic [2*DIV_DATA_W-1:0] pack_result(
        input logic [DIV_DATA_W-1:0] rem,
        input logic [DIV_DATA_W-1:0] quo
    );
        return {rem, quo};
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left, trial-subtract the
// divisor, keep the difference and set the quotient bit when it fits.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W-1:0] rq,
    input  logic [DATA_W-1:0]   divisor,
    output logic [2*DATA_W-1:0] rq_next
);

    // The shifted partial remainder needs DATA_W+1 bits; the subtraction
    // result always fits DATA_W bits whenever partial >= divisor.
    logic [DATA_W:0]   partial;
    logic [DATA_W-1:0] rem_sub;

    // Trial subtraction and restore decision.
    always_comb begin
        partial = rq[2*DATA_W-1:DATA_W-1];
        rem_sub = partial[DATA_W-1:0] - divisor;
        if (partial >= {1'b0, divisor})
            rq_next = {rem_sub, rq[DATA_W-2:0], 1'b1};
        else
            rq_next = {partial[DATA_W-1:0], rq[DATA_W-2:0], 1'b0};
    end

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: start/ready handshake with EX, stall request while
// busy, result {HI=remainder, LO=quotient}. Optional macro
// DIV_CTRL_FASTPATH_EN finishes in one cycle when |dividend| < |divisor|.
module div_ctrl
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                annul_i,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                stall_req_o
);

    div_state_t          state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] rq, rq_next;
    logic [DATA_W-1:0]   dvs;
    logic                sgn, s1, s2;

    logic [DATA_W-1:0]   a_abs, b_abs, quo_fix, rem_fix;
    logic                accept, last_step;

    assign accept    = start_i & ~annul_i;
    assign last_step = (cnt == CNT_W'(DIV_STEPS - 1));
    assign a_abs     = (signed_div_i & opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign b_abs     = (signed_div_i & opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // Sign fix-up applied to the value produced by the final iteration;
    // the remainder takes the dividend's sign, the quotient the xor of signs.
    assign quo_fix = (sgn & (s1 ^ s2)) ? -rq_next[DATA_W-1:0] : rq_next[DATA_W-1:0];
    assign rem_fix = (sgn & s1) ? -rq_next[2*DATA_W-1:DATA_W] : rq_next[2*DATA_W-1:DATA_W];

    div_step #(.DATA_W(DATA_W)) u_step (
        .rq      (rq),
        .divisor (dvs),
        .rq_next (rq_next)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and combinational stall request.
    always_comb begin
        state_next  = state;
        stall_req_o = 1'b0;
        case (state)
            IDLE: begin
                stall_req_o = accept;
                if (accept) begin
                    if (opdata2_i == '0)
                        state_next = BY_ZERO;
`ifdef DIV_CTRL_FASTPATH_EN
                    else if (a_abs < b_abs)
                        state_next = END;
`endif
                    else
                        state_next = ON;
                end
            end
            BY_ZERO: begin
                stall_req_o = 1'b1;
                state_next  = annul_i ? IDLE : END;
            end
            ON: begin
                stall_req_o = 1'b1;
                if (annul_i)        state_next = IDLE;
                else if (last_step) state_next = END;
            end
            END: begin
                if (!start_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, result register and ready flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rq       <= '0;
            dvs      <= '0;
            sgn      <= 1'b0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == ON) begin
                        rq  <= {{DATA_W{1'b0}}, a_abs};
                        dvs <= b_abs;
                        sgn <= signed_div_i;
                        s1  <= opdata1_i[DATA_W-1];
                        s2  <= opdata2_i[DATA_W-1];
                        cnt <= '0;
                    end else if (state_next == END) begin
                        // fast path: quotient 0, remainder is the raw dividend
                        result_o <= pack_result(opdata1_i, '0);
                        ready_o  <= 1'b1;
                    end
                end
                BY_ZERO: begin
                    if (state_next == END) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        rq  <= rq_next;
                        cnt <= cnt + CNT_W'(1);
                        if (state_next == END) begin
                            result_o <= pack_result(rem_fix, quo_fix);
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (state_next == IDLE) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed plan cases plus randomized
// operands against an arithmetic reference (longint divide/modulo).
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, annul, sg;
    logic [31:0] op1, op2;
    logic [63:0] result;
    logic        ready, stall;

    int n_tests = 0;
    int n_fail  = 0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .annul_i      (annul),
        .signed_div_i (sg),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .result_o     (result),
        .ready_o      (ready),
        .stall_req_o  (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic (truncating division,
    // remainder follows dividend), divide by zero fixed at 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 0) return 64'h0;
        sa = s ? longint'($signed(a)) : longint'({32'h0, a});
        sb = s ? longint'($signed(b)) : longint'({32'h0, b});
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint ma, mb;
        ma = s ? longint'($signed(a)) : longint'({32'h0, a});
        mb = s ? longint'($signed(b)) : longint'({32'h0, b});
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        if (b == 0) return 2;
`ifdef DIV_CTRL_FASTPATH_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Wait (bounded) for ready; returns cycles elapsed and whether stall held.
    task automatic wait_ready(input int budget, output int cyc, output bit stall_ok);
        cyc = 0;
        stall_ok = 1'b1;
        while (cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                op1 = $urandom;   // post-acceptance operand changes must not matter
                op2 = $urandom;
                sg  = $urandom_range(0, 1);
            end
            if (ready) break;
            if (!stall) stall_ok = 1'b0;
        end
    endtask

    // Full transaction: issue at current cycle (cycle 0), hold start until ready.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        int cyc;
        bit sok;
        logic [63:0] exp;
        int lat;
        exp = ref_div(a, b, s);
        lat = ref_lat(a, b, s);
        op1 = a; op2 = b; sg = s; start = 1'b1; annul = 1'b0;
        #1;
        chk({tag, " stall_c0"}, 64'(stall), 64'h1);
        wait_ready(40, cyc, sok);
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " result"}, result, exp);
        chk({tag, " stall_busy"}, 64'(sok), 64'h1);
        chk({tag, " stall_rdy"}, 64'(stall), 64'h0);
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, " ready_drop"}, 64'(ready), 64'h0);
        chk({tag, " result_drop"}, result, 64'h0);
    endtask

    initial begin
        int cyc;
        bit sok;
        rst = 1'b1; start = 1'b0; annul = 1'b0; sg = 1'b0; op1 = '0; op2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", 64'(ready), 64'h0);
        chk("rst result", result, 64'h0);
        chk("rst stall", 64'(stall), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed plan cases
        run_div("u100_7", 32'd100, 32'd7, 1'b0);
        chk("u100_7 model", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        run_div("sm7_2", 32'hFFFFFFF9, 32'h2, 1'b1);
        run_div("s7_m2", 32'h7, 32'hFFFFFFFE, 1'b1);
        run_div("dz", 32'h1234, 32'h0, 1'b0);
        run_div("ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1);
        run_div("u5_9", 32'd5, 32'd9, 1'b0);
        run_div("s_m5_9", 32'hFFFFFFFB, 32'd9, 1'b1);

        // annul at cycle 10, restart at cycle 12
        op1 = 32'd100; op2 = 32'd7; sg = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        start = 1'b0; annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        chk("annul stall", 64'(stall), 64'h0);
        chk("annul ready", 64'(ready), 64'h0);
        @(posedge clk); #1;
        chk("annul ready2", 64'(ready), 64'h0);
        run_div("after_annul", 32'd100, 32'd7, 1'b0);

        // reset mid-operation at cycle 15, start held through it
        op1 = 32'd100; op2 = 32'd7; sg = 1'b0; start = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst ready", 64'(ready), 64'h0);
        chk("midrst result", result, 64'h0);
        rst = 1'b0;
        op1 = 32'd100; op2 = 32'd7; sg = 1'b0;
        wait_ready(40, cyc, sok);
        chk("midrst latency", 64'(cyc), 64'd33);
        chk("midrst rslt", result, 64'h00000002_0000000E);
        start = 1'b0;
        @(posedge clk); #1;

        // randomized operands, biased toward interesting values
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            logic s;
            a = $urandom;
            b = $urandom;
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 3));
                1: b = {{16{b[15]}}, b[15:0]};
                2: a = a >> $urandom_range(0, 31);
                3: begin a = 32'h80000000; b = $urandom_range(0, 1) ? 32'hFFFFFFFF : b; end
                default: ;
            endcase
            run_div($sformatf("rnd%0d", i), a, b, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Iterative radix-2 restoring divider plus its sequencing FSM for DIV/DIVU. EX hands operands over with a start/ready handshake. The block holds the pipeline via a stall request for the whole operation, then returns {HI=remainder, LO=quotient} for the HI/LO write path. It is a single-requester resource owner; EX is the only client.

Parameters:
DATA_W, 32, operand width; the 64-bit result is 2*DATA_W
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high (`RstEnable` = 1)
start_i  in  1  divide request from EX; held high until ready_o is seen
annul_i  in  1  cancel request (exception/flush in a later stage)
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
opdata1_i  in  DATA_W  dividend; sampled only on the accepting cycle
opdata2_i  in  DATA_W  divisor; sampled only on the accepting cycle
result_o  out  2*DATA_W  {remainder, quotient}
ready_o  out  1  result valid
stall_req_o  out  1  pipeline hold request to the stall controller

Behaviour:
- States: IDLE, BY_ZERO, ON, END, encoded as div_state_t.
- Reset (rst=1 at a clock edge): state←IDLE, counter←0, result_o←0, ready_o←0, working registers←0. Reset overrides everything, including mid-operation.
- IDLE:
  - start_i=1 and annul_i=0 and divisor=0 → BY_ZERO.
  - start_i=1 and annul_i=0 and divisor≠0 → ON. Latch |dividend| and |divisor| (absolute values only when signed_div_i=1), latch both sign bits and signed_div_i, counter←0.
  - Any other combination: remain in IDLE.
- BY_ZERO: next cycle → END with result 0. MIPS leaves this case unpredictable; the team fixes it at 0.
- ON: one restoring step per cycle, i.e. shift {rem,quo} left by 1, trial-subtract the divisor, keep the result if non-negative and set the quotient bit. Counter increments each step. After DATA_W steps → END.
- END, on entry:
  - signed and dividend sign ≠ divisor sign → quotient negated (two's complement);
  - signed and dividend negative → remainder negated (remainder sign follows the dividend);
  - result_o registered and ready_o=1.
  - Stays in END while start_i=1. On start_i=0 → IDLE, ready_o←0, result_o←0.
- annul_i=1 in BY_ZERO or ON → IDLE next cycle, ready_o=0, no result. annul_i in END is ignored; the result is already produced.
- stall_req_o is combinational and equals (IDLE & start_i & ~annul_i) | BY_ZERO | ON. It is 0 in END, so EX advances on the ready cycle.
- Latency: start accepted at cycle 0, ON for cycles 1..32, ready_o=1 in cycle 33 (DATA_W=32). Divide by zero gives ready in cycle 2.
- Corner case: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0. This is the natural wrap; no trap.
- opdata changes after acceptance have no effect.

Optional Feature:
DIV_CTRL_FASTPATH_EN
- Defined: in IDLE, if |dividend| < |divisor| (magnitude compare after abs), go straight to END with quotient=0 and remainder=dividend (sign preserved). Ready appears in cycle 1.
- Undefined: all non-zero divisors take the full DATA_W iterations; the comparator is not built.

Decomposition:
- Shared package div_pkg holds:
  - typedef enum div_state_t {IDLE, BY_ZERO, ON, END};
  - localparam DIV_STEPS = DATA_W;
  - the result packing helper: remainder in [63:32], quotient in [31:0].
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial {rem,quo} and divisor.
  - Outputs: next {rem,quo}.
- div_ctrl owns the FSM, counter, sign fix-up and handshake.

Test Plan:
- Unsigned: 100 / 7, start held → stall_req_o high cycles 0..32; ready_o=1 at cycle 33 with result_o=64'h00000002_0000000E; drop start → ready_o=0, result_o=0 next cycle.
- Signed: -7 / 2 (0xFFFFFFF9 / 0x00000002) → result_o=64'hFFFFFFFF_FFFFFFFD. Also 7 / -2 → 64'h00000001_FFFFFFFD.
- Divide by zero: 0x1234 / 0 → BY_ZERO at cycle 1, ready at cycle 2 with result_o=0; stall_req_o is 0 in the ready cycle.
- Annul: start 100/7, annul_i=1 at cycle 10 → IDLE at cycle 11, stall_req_o=0, ready_o never asserts. A new start at cycle 12 completes normally at cycle 45.
- Reset mid-operation: rst=1 at cycle 15 → at the next edge all outputs are 0 and the state is IDLE. With start still high after rst drops, the operation restarts from cycle 0.
- Overflow corner and fast path:
  - signed 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
  - With DIV_CTRL_FASTPATH_EN, unsigned 5 / 9 → ready at cycle 1 with 64'h00000005_00000000.
  - Without it, the same 5 / 9 case gives ready at cycle 33.
